// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, with wrap.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [grant_w(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [grant_w(NUM_REQ)-1:0] gnt_idx
);
    localparam int IW = grant_w(NUM_REQ);

    // Walk slots ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last slot is ptr itself.
    always_comb begin
        int  c;
        logic found;
        c       = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt_idx = IW'(c);
            end
        end
        gnt[gnt_idx] = found;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters,
// with SETUP/ACCESS sequencing and a PREADY timeout guard.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic [grant_w(NUM_REQ)-1:0]   grant_id,
    output logic                          busy,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_W-1:0]             paddr,
    output logic [DATA_W-1:0]             pwdata,
    output logic [DATA_W/8-1:0]           pstrb,
    output logic [2:0]                    pprot,
    input  logic [DATA_W-1:0]             prdata,
    input  logic                          pready,
    input  logic                          pslverr
);
    localparam int IW = grant_w(NUM_REQ);
    localparam int SW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e         state, state_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [IW-1:0]      ptr;
    logic [CW-1:0]      wait_cnt;
    logic               timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any     = |gnt;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));
    assign pprot       = PPROT_DEFAULT;

    // Next state plus state-decoded APB controls; decoding from the
    // async-reset state register makes them drop as soon as rst asserts.
    always_comb begin
        state_nxt  = state;
        psel       = 1'b0;
        penable    = 1'b0;
        busy       = (state != IDLE);
        resp_valid = '0;
        case (state)
            IDLE:   if (gnt_any) state_nxt = SETUP;
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                resp_valid[grant_id] = 1'b1;
                state_nxt            = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the winner's command at grant; held untouched until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= IW'(NUM_REQ - 1);
            grant_id <= '0;
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            pstrb    <= '0;
        end else if (state == IDLE && gnt_any) begin
            ptr      <= gnt_idx;
            grant_id <= gnt_idx;
            paddr    <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            pwrite   <= req_write[gnt_idx];
            pwdata   <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            pstrb    <= req_strb[int'(gnt_idx)*SW +: SW];
        end
    end

    // ACCESS wait counter; restarts every SETUP so each transfer gets the full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        wait_cnt <= '0;
        else if (state == SETUP)                        wait_cnt <= '0;
        else if (state == ACCESS && !pready && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
    end

    // Completion capture; held until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (state == ACCESS && pready) begin
            resp_rdata <= pwrite ? '0 : prdata;
            resp_err   <= pslverr;
        end else if (state == ACCESS && timeout_hit) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with hand-computed expectations.
module tb_apb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N*DW/8-1:0] req_strb = '0;
    logic [N-1:0]      resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;
    logic [1:0]        grant_id;
    logic              busy, psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic [2:0]        pprot;
    logic [DW-1:0]     prdata = '0;
    logic              pready = 1'b1;
    logic              pslverr = 1'b0;

    int checks = 0;
    int errors = 0;
    int n;

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .grant_id(grant_id), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", resp_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_pprot", pprot, 0);
        rst = 1'b0;
        tick();

        // single zero-wait write from requester 0
        req_addr[0*AW +: AW]  = 32'h10;
        req_wdata[0*DW +: DW] = 32'hA5A5_0001;
        req_strb[0*4 +: 4]    = 4'hF;
        req_write[0]          = 1'b1;
        req                   = 4'b0001;
        tick();
        chk("w_setup_psel", psel, 1);
        chk("w_setup_pen", penable, 0);
        chk("w_paddr", paddr, 32'h10);
        chk("w_pwrite", pwrite, 1);
        chk("w_pwdata", pwdata, 32'hA5A5_0001);
        chk("w_pstrb", pstrb, 4'hF);
        chk("w_gid", grant_id, 0);
        chk("w_busy", busy, 1);
        tick();
        chk("w_acc_psel", psel, 1);
        chk("w_acc_pen", penable, 1);
        chk("w_acc_rv", resp_valid, 0);
        tick();
        chk("w_done_rv", resp_valid, 4'b0001);
        chk("w_done_err", resp_err, 0);
        chk("w_done_psel", psel, 0);
        chk("w_done_rdata", resp_rdata, 0);
        req = '0;
        tick();
        chk("w_idle_busy", busy, 0);
        chk("w_idle_rv", resp_valid, 0);

        // read with 3 wait states from requester 2
        req_addr[2*AW +: AW] = 32'h24;
        req_write[2]         = 1'b0;
        prdata               = 32'hDEAD_BEEF;
        req                  = 4'b0100;
        tick();
        chk("r_gid", grant_id, 2);
        chk("r_paddr", paddr, 32'h24);
        pready = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!penable) break;
            n++;
            chk("r_paddr_stable", paddr, 32'h24);
            pready = (n == 4);
        end
        chk("r_access_len", n, 4);
        chk("r_rv", resp_valid, 4'b0100);
        chk("r_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("r_err", resp_err, 0);
        req = '0;
        pready = 1'b1;
        tick();

        // pslverr on a write from requester 1, then a clean transfer from requester 3
        req_addr[1*AW +: AW] = 32'h30;
        req_write[1]         = 1'b1;
        pslverr              = 1'b1;
        req                  = 4'b0010;
        tick();
        chk("e_gid", grant_id, 1);
        tick();
        tick();
        chk("e_rv", resp_valid, 4'b0010);
        chk("e_err", resp_err, 1);
        pslverr              = 1'b0;
        req_addr[3*AW +: AW] = 32'h3C;
        req_write[3]         = 1'b1;
        req                  = 4'b1000;
        tick();
        tick();
        chk("e2_gid", grant_id, 3);
        tick();
        tick();
        chk("e2_rv", resp_valid, 4'b1000);
        chk("e2_err", resp_err, 0);
        req = '0;
        tick();

        // all four held: grant order 0,1,2,3,0,1, one transfer every 4 cycles
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 32'h100 + i * 4;
            req_write[i]         = 1'b0;
        end
        prdata = 32'hCAFE_0000;
        req    = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_setup_psel", {psel, penable}, 2'b10);
            chk("rr_gid", grant_id, k % 4);
            chk("rr_paddr", paddr, 32'h100 + (k % 4) * 4);
            tick();
            tick();
            chk("rr_rv", resp_valid, 4'b0001 << (k % 4));
            chk("rr_rdata", resp_rdata, 32'hCAFE_0000);
            if (k == 5) req = '0;
            tick();
            chk("rr_idle_psel", psel, 0);
        end

        // pready stuck low: timeout after 16 ACCESS cycles, then serve requester 3
        req_write[2]          = 1'b1;
        req_write[3]          = 1'b0;
        req                   = 4'b0100;
        pready                = 1'b0;
        tick();
        chk("t_gid", grant_id, 2);
        req[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!penable) break;
            n++;
        end
        chk("t_pen_len", n, 16);
        chk("t_rv", resp_valid, 4'b0100);
        chk("t_err", resp_err, 1);
        chk("t_rdata", resp_rdata, 0);
        req[2] = 1'b0;
        pready = 1'b1;
        prdata = 32'h1234_5678;
        tick();
        chk("t_idle_busy", busy, 0);
        tick();
        chk("t_next_gid", grant_id, 3);
        tick();
        tick();
        chk("t_next_rv", resp_valid, 4'b1000);
        chk("t_next_err", resp_err, 0);
        chk("t_next_rdata", resp_rdata, 32'h1234_5678);
        req = '0;
        tick();

        // reset in ACCESS: async drop, then requester 0 first
        req    = 4'b0010;
        pready = 1'b0;
        tick();
        tick();
        chk("x_acc_pen", penable, 1);
        #2 rst = 1'b1;
        #1;
        chk("x_psel", psel, 0);
        chk("x_pen", penable, 0);
        chk("x_busy", busy, 0);
        chk("x_rv", resp_valid, 0);
        tick();
        chk("x_held_rv", resp_valid, 0);
        rst    = 1'b0;
        pready = 1'b1;
        req    = 4'b1001;
        tick();
        chk("x_gid0", grant_id, 0);
        tick();
        tick();
        chk("x_rv0", resp_valid, 4'b0001);
        req = 4'b1000;
        tick();
        tick();
        chk("x_gid3", grant_id, 3);
        req = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
